// File: rtl/dev_int_arbiter_if.sv
// Bus bundle between the interrupt arbiter, the device CSRs and the CPU.
//   dev_csr  : concatenated 8-bit device CSRs, device i at [8i+7:8i]
//   gie      : global interrupt enable from the CPU PSW
//   irq_ack  : CPU accepted the current request (level)
//   irq      : interrupt request to the CPU
//   irq_vec  : vector address of the granted device
//   irq_dev  : index of the granted device
//   dba_clr  : one-hot, one-cycle strobe asking device i to clear DBA
//   clr_err  : one-cycle pulse when a device failed to drop DBA in time
// The slave modport is the arbiter's view; master is the CPU/device side.
interface dev_int_arbiter_if #(
   parameter int NUM_DEV = 4
);
   logic [8*NUM_DEV-1:0] dev_csr;
   logic                 gie;
   logic                 irq_ack;
   logic                 irq;
   logic [15:0]          irq_vec;
   logic [2:0]           irq_dev;
   logic [NUM_DEV-1:0]   dba_clr;
   logic                 clr_err;

   modport slave (
      input  dev_csr, gie, irq_ack,
      output irq, irq_vec, irq_dev, dba_clr, clr_err
   );

   modport master (
      output dev_csr, gie, irq_ack,
      input  irq, irq_vec, irq_dev, dba_clr, clr_err
   );
endinterface

// File: rtl/dev_int_arbiter.sv
// Round-robin interrupt arbiter for memory-mapped devices with an 8-bit CSR.
// A device requests service while IE (bit 4) and DBA (bit 2) are both set.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-high reset
//   bus : dev_int_arbiter_if.slave (CSRs, gie, irq_ack in; irq, irq_vec,
//         irq_dev, dba_clr, clr_err out; all outputs registered)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no request outstanding; arbitrate when gie and any pend
// REQ      | irq high to CPU, waiting for irq_ack or withdrawal
// ACK      | one cycle: dba_clr strobe to granted device, pointer updated
// WAIT_CLR | waiting for granted device to drop DBA, bounded by timeout
module dev_int_arbiter #(
   parameter int          NUM_DEV     = 4,
   parameter logic [15:0] VEC_BASE    = 16'hFFC0,
   parameter int          VEC_STRIDE  = 4,
   parameter int          CLR_TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   dev_int_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_ACK,
      S_WAIT_CLR
   } state_t;

   state_t             state_q, state_d;
   logic [2:0]         last_q, last_d;
   logic [2:0]         irq_dev_q, irq_dev_d;
   logic [15:0]        irq_vec_q, irq_vec_d;
   logic               irq_q, irq_d;
   logic [NUM_DEV-1:0] dba_clr_q, dba_clr_d;
   logic               clr_err_q, clr_err_d;
   logic [7:0]         cnt_q, cnt_d;

   logic [7:0]         pend;
   logic [2:0]         win;
   logic               win_vld;
   logic [2:0]         cand;

   // Padded to 8 bits so the 3-bit device index never selects out of range.
   always_comb begin
      pend = '0;
      for (int i = 0; i < NUM_DEV; i++) begin
         pend[i] = bus.dev_csr[8*i+4] & bus.dev_csr[8*i+2];
      end
   end

   // Search starts one past the last completed grant and wraps.
   always_comb begin
      win     = '0;
      win_vld = 1'b0;
      cand    = '0;
      for (int k = 1; k <= NUM_DEV; k++) begin
         cand = 3'((int'(last_q) + k) % NUM_DEV);
         if (!win_vld && pend[cand]) begin
            win     = cand;
            win_vld = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         last_q    <= 3'(NUM_DEV - 1);
         irq_dev_q <= '0;
         irq_vec_q <= '0;
         irq_q     <= 1'b0;
         dba_clr_q <= '0;
         clr_err_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         irq_dev_q <= irq_dev_d;
         irq_vec_q <= irq_vec_d;
         irq_q     <= irq_d;
         dba_clr_q <= dba_clr_d;
         clr_err_q <= clr_err_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      irq_dev_d = irq_dev_q;
      irq_vec_d = irq_vec_q;
      irq_d     = 1'b0;
      dba_clr_d = '0;
      clr_err_d = 1'b0;
      cnt_d     = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.gie && win_vld) begin
               state_d   = S_REQ;
               irq_d     = 1'b1;
               irq_dev_d = win;
               irq_vec_d = VEC_BASE + 16'(VEC_STRIDE) * {13'd0, win};
            end
         end

         S_REQ: begin
            // Ack wins over a simultaneous withdrawal.
            if (bus.irq_ack) begin
               state_d = S_ACK;
               last_d  = irq_dev_q;
               cnt_d   = '0;
               for (int i = 0; i < NUM_DEV; i++) begin
                  dba_clr_d[i] = (irq_dev_q == 3'(i));
               end
            end else if (!pend[irq_dev_q] || !bus.gie) begin
               state_d = S_IDLE;
            end else begin
               irq_d = 1'b1;
            end
         end

         S_ACK: begin
            // The ACK cycle is the first counted cycle, so the error pulse
            // lands CLR_TIMEOUT cycles after the edge that entered ACK.
            state_d = S_WAIT_CLR;
            cnt_d   = 8'd1;
         end

         S_WAIT_CLR: begin
            cnt_d = cnt_q + 8'd1;
            if (!pend[irq_dev_q]) begin
               state_d = S_IDLE;
            end else if (cnt_q >= 8'(CLR_TIMEOUT - 1)) begin
               state_d   = S_IDLE;
               clr_err_d = 1'b1;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign bus.irq     = irq_q;
   assign bus.irq_vec = irq_vec_q;
   assign bus.irq_dev = irq_dev_q;
   assign bus.dba_clr = dba_clr_q;
   assign bus.clr_err = clr_err_q;

endmodule

// File: doc/dev_int_arbiter.md
Name: dev_int_arbiter

Overview:
- Round-robin interrupt arbiter for the memory-mapped I/O devices (pedestrian button and peers) that expose an 8-bit CSR.
- A device requests service when its CSR has IE (bit 4) and DBA (bit 2) both set.
- The arbiter selects one requester, presents an interrupt request and vector address to the CPU, and waits for the CPU's acknowledge.
- After the acknowledge it pulses a DBA-clear strobe back to the granted device and waits for that device's DBA to drop.

Parameters:
- NUM_DEV, 4, number of devices arbitrated (1..8).
- VEC_BASE, 16'hFFC0, vector address of device 0.
- VEC_STRIDE, 4, byte spacing between consecutive device vectors.
- CLR_TIMEOUT, 15, maximum number of cycles to wait in WAIT_CLR for DBA to drop (1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- dev_csr  in  8*NUM_DEV  concatenated device CSRs; device i occupies [8i+7:8i].
- gie  in  1  global interrupt enable from the CPU PSW.
- irq_ack  in  1  CPU accepted the current request; level, sampled each cycle.
- irq  out  1  interrupt request to the CPU.
- irq_vec  out  16  vector address of the granted device.
- irq_dev  out  3  index of the granted device.
- dba_clr  out  NUM_DEV  one-hot, one-cycle strobe telling device i to clear DBA.
- clr_err  out  1  one-cycle pulse when the CLR_TIMEOUT expires.

Behaviour:
- pend[i] = dev_csr[8i+4] & dev_csr[8i+2]; combinational, unregistered.
- Reset (rst=1 at a clock edge):
  - state=IDLE, irq=0, irq_vec=0, irq_dev=0, dba_clr=0, clr_err=0, timeout counter=0.
  - Round-robin pointer last=NUM_DEV-1, so device 0 has first priority after reset.
  - Reset overrides every state, including mid-handshake; any dba_clr strobe due that cycle is not issued.
- Arbitration:
  - Search starts at last+1 and wraps modulo NUM_DEV.
  - The first i with pend[i]=1 wins.
  - last updates to the winner only when the grant completes (ACK state), not at selection.
- IDLE:
  - If gie=1 and any pend bit is set, latch the winner into irq_dev and irq_vec = VEC_BASE + VEC_STRIDE*winner (16-bit, wraps modulo 2^16), then go to REQ.
  - Consequently irq rises exactly 1 cycle after the qualifying pend/gie are seen.
- REQ:
  - irq=1; irq_vec and irq_dev held stable.
  - irq_ack=1 → go to ACK. Ack takes precedence even if pend or gie drops in the same cycle.
  - Otherwise, pend[irq_dev]=0 or gie=0 → withdraw: go to IDLE, irq=0, no dba_clr, last unchanged.
  - Otherwise stay in REQ, for unbounded time.
- ACK (exactly 1 cycle):
  - irq=0, dba_clr[irq_dev]=1, last=irq_dev, counter=0, then go to WAIT_CLR.
- WAIT_CLR:
  - dba_clr=0. Counter increments each cycle.
  - pend[irq_dev]=0 → IDLE. New arbitration is possible on the next cycle.
  - Counter reaches CLR_TIMEOUT with pend[irq_dev] still 1 → clr_err=1 for 1 cycle, go to IDLE.
  - That device may then win again only after the other requesters, because last already points at it.
- irq_ack outside REQ is ignored.
- Requests from other devices arriving during REQ/ACK/WAIT_CLR stay pending; nothing is latched or lost, because the device holds DBA.
- Minimum grant cycle when DBA drops the cycle after dba_clr: IDLE→REQ→ACK→WAIT_CLR→IDLE, 4 cycles plus CPU ack latency.
- irq_vec and irq_dev retain their last value outside REQ. They are only meaningful while irq=1.

Test Plan:
- Single requester: reset, then dev_csr[1] = 8'h14, gie=1 → irq=1 after 1 cycle with irq_dev=1, irq_vec=16'hFFC4. Assert irq_ack 3 cycles later → next cycle irq=0, dba_clr=4'b0010 for 1 cycle. Clear DBA → back to IDLE.
- Round-robin fairness: devices 0, 2 and 3 continuously pending, device model clears DBA then re-asserts it, immediate ack → grant order 0, 2, 3, 0, 2, 3.
- Withdraw: in REQ for device 2, clear dev_csr[2] bit 4 before ack → irq drops the next cycle, no dba_clr pulse, next grant still starts search at the old last+1.
- Gating and simultaneity: gie=0 with device 0 pending → irq stays 0. In REQ, drop pend in the same cycle irq_ack=1 → ACK still taken, dba_clr issued.
- Timeout: device never clears DBA → clr_err pulses exactly CLR_TIMEOUT (15) cycles after the ACK-cycle edge, then the other pending device 1 is granted before device 0 again.
- Reset mid-operation: assert rst while in REQ and while in ACK → next cycle all outputs 0, state IDLE, device 0 has priority on the next arbitration.
